booth_dot_accumulator: RTL and testbench
========================================

# booth_dot_accumulator

Streaming accumulation stage that sits directly downstream of the registered Booth multiplier. It consumes the 64-bit signed products the multiplier emits and sums a variable-length run of them (one vector, terminated by `in_last`) into a wide signed accumulator. It presents the dot-product result over a valid/ready handshake, together with a term count and a sticky overflow flag. It turns the multiplier into a dot-product engine without changing the multiplier.

## Interface
- `PROD_W`, 64, width of the incoming signed product
- `ACC_W`, 72, accumulator/result width; must be ≥ `PROD_W`
- `CNT_W`, 8, width of the term counter

- `clk`  input  1  single clock, rising edge
- `reset`  input  1  asynchronous, active-high; clears all state immediately
- `in_valid`  input  1  product present on `product`
- `in_ready`  output  1  block can accept a product this cycle
- `product`  input  PROD_W  signed product from the multiplier
- `in_last`  input  1  qualifies `product` as the final term of the vector
- `out_valid`  output  1  result registers hold a completed vector
- `out_ready`  input  1  consumer accepts the result
- `acc_out`  output  ACC_W  signed dot-product result (wrapped on overflow)
- `terms`  output  CNT_W  number of products in the vector, saturating at 2^CNT_W−1
- `overflow`  output  1  signed overflow occurred at some point in this vector

## Operation
- Two states:
  - ACCUM (reset state): `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Accept occurs when `in_valid && in_ready`. On each accept:
  - `sum = acc + sext(product)`, computed at ACC_W+1 bits.
  - acc ← `sum[ACC_W-1:0]` (two's-complement wrap).
  - ovf_sticky ← ovf_sticky | (`sum[ACC_W]` ≠ `sum[ACC_W-1]`).
  - cnt ← cnt+1, saturating at all-ones.
- Accept with `in_last`=0: stay in ACCUM.
- Accept with `in_last`=1: load `acc_out`, `overflow`, `terms` from the post-update values. Clear the internal acc, cnt and ovf_sticky. Go to HOLD.
- HOLD with `out_ready`=1: go to ACCUM on the next edge; `out_valid` falls. `acc_out`, `terms`, `overflow` keep their values until the next vector completes.
- HOLD with `out_ready`=0: remain in HOLD; all outputs stable.
- `in_valid` and `product` are ignored while in HOLD. The producer must hold its data, since `in_ready`=0.
- No zero-length vectors: a vector is at least one accepted product.
- Sign rule: `product` is sign-extended from PROD_W to ACC_W. The accumulator is always signed.

## Timing
- Reset values: state ACCUM, `in_ready`=1 (once `reset` is deasserted), `out_valid`=0, `acc_out`=0, `terms`=0, `overflow`=0. Internal acc, cnt and sticky are all 0.
- Latency: `out_valid` rises on the edge that accepts the `in_last` product. The result is visible in the following cycle.
- Throughput: one product per cycle within a vector. There is at least one cycle with `in_ready`=0 between vectors (the HOLD cycle), or more while `out_ready`=0.
- `in_ready` is a decode of the state register only. There is no combinational path from `out_ready` or `in_valid`.
- `out_ready` asserted while in ACCUM has no effect.
- Reset mid-vector or mid-HOLD: the partial sum and any pending result are discarded. All registers return to their reset values asynchronously.

## Test plan
- Basic 3-term vector, no backpressure (defaults):
  - Stimulus: products 6, −4, 10 on consecutive cycles, `in_last` on 10, `out_ready`=1.
  - Response: `out_valid` for exactly 1 cycle, then `in_ready` returns. `acc_out`=12, `terms`=3, `overflow`=0.
- Backpressure in HOLD:
  - Stimulus: single-term vector with product −0x7FFF_FFFF_0000_0001 (`in_last`=1), then `out_ready`=0 for 5 cycles while `in_valid` is held high with product 99.
  - Response: `out_valid`=1 and `in_ready`=0 throughout. `acc_out` equals the sign-extended product, `terms`=1. The 99 is only accepted after `out_ready` is raised.
- Overflow and wrap (`ACC_W`=66):
  - Stimulus: 5 products of 0x7FFF_FFFF_FFFF_FFFF with `in_last` on the 5th.
  - Response: `overflow`=1, `acc_out` = 5·(2^63−1) mod 2^66 as a signed value, `terms`=5.
  - Follow-up: the next vector (product 1, last) gives `overflow`=0 and `acc_out`=1.
- Counter saturation (`CNT_W`=3):
  - Stimulus: 10 products of 1, last on the 10th.
  - Response: `terms`=7, `acc_out`=10.
- Asynchronous reset mid-vector:
  - Stimulus: after 2 accepts of 50, pulse `reset` between clock edges, then send vector {3 (last)}.
  - Response: outputs go to 0 immediately, without waiting for a clock edge. The next result is `acc_out`=3, `terms`=1.
- Back-to-back vectors with the multiplier in front:
  - Stimulus: drive a={2,−3}, b={7,5} through the multiplier, last on the second pair.
  - Response: `acc_out`=−1, `terms`=2, one HOLD cycle.

Source files
------------

// File: rtl/booth_dot_accumulator.sv
// Streaming dot-product accumulator behind the Booth multiplier: sums signed
// products until in_last, then holds the result on a valid/ready handshake.
module booth_dot_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  terms,
  output logic              overflow
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               ovf_reg;

  logic               accept;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt_next;
  logic               ovf_next;

  // Handshake flags decode the state register only.
  assign in_ready  = (state_reg == ACCUM);
  assign out_valid = (state_reg == HOLD);
  assign accept    = in_valid && in_ready;

  // One guard bit above the accumulator exposes signed overflow.
  assign sum      = {acc_reg[ACC_W-1], acc_reg}
                  + {{(ACC_W + 1 - PROD_W){product[PROD_W-1]}}, product};
  assign acc_next = sum[ACC_W-1:0];
  assign ovf_next = ovf_reg | (sum[ACC_W] != sum[ACC_W-1]);
  assign cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ACCUM;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM:   if (accept && in_last) state_next = HOLD;
      HOLD:    if (out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg  <= '0;
      cnt_reg  <= '0;
      ovf_reg  <= 1'b0;
      acc_out  <= '0;
      terms    <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        // Publish post-update values and start the next vector from zero.
        acc_out  <= acc_next;
        terms    <= cnt_next;
        overflow <= ovf_next;
        acc_reg  <= '0;
        cnt_reg  <= '0;
        ovf_reg  <= 1'b0;
      end else begin
        acc_reg  <= acc_next;
        cnt_reg  <= cnt_next;
        ovf_reg  <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_booth_dot_accumulator.sv
// Bench for booth_dot_accumulator: three width variants driven in lockstep,
// checked against a wide-integer scoreboard model.
module tb_booth_dot_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid = 1'b0;
  logic [63:0] product = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        rdy_a, vld_a, ovf_a, rdy_b, vld_b, ovf_b, rdy_c, vld_c, ovf_c;
  logic [71:0] acc_a, acc_c;
  logic [65:0] acc_b;
  logic [7:0]  terms_a, terms_b;
  logic [2:0]  terms_c;

  always #5 clk = ~clk;

  booth_dot_accumulator dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a),
    .product(product), .in_last(in_last), .out_valid(vld_a),
    .out_ready(out_ready), .acc_out(acc_a), .terms(terms_a), .overflow(ovf_a));

  booth_dot_accumulator #(.ACC_W(66)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b),
    .product(product), .in_last(in_last), .out_valid(vld_b),
    .out_ready(out_ready), .acc_out(acc_b), .terms(terms_b), .overflow(ovf_b));

  booth_dot_accumulator #(.CNT_W(3)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_c),
    .product(product), .in_last(in_last), .out_valid(vld_c),
    .out_ready(out_ready), .acc_out(acc_c), .terms(terms_c), .overflow(ovf_c));

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic signed [127:0] obs,
                          input logic signed [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference model, one slot per variant: a=(72,8) b=(66,8) c=(72,3).
  int aw [3] = '{72, 66, 72};
  int cw [3] = '{8, 8, 3};
  logic signed [127:0] m_acc [3];
  int                  m_cnt [3];
  bit                  m_ovf [3];

  typedef struct packed {
    logic [2:0][127:0] acc;
    logic [2:0][31:0]  cnt;
    logic [2:0]        ovf;
  } exp_t;
  exp_t exp_q [$];

  function automatic void model_clear();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = '0;
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endfunction

  function automatic void model_accept(input logic [63:0] p, input bit last);
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      logic signed [127:0] s, span, lim;
      span = 128'sd1 <<< aw[k];
      lim  = span >>> 1;
      s = m_acc[k] + $signed({{64{p[63]}}, p});
      if (s >= lim || s < -lim) m_ovf[k] = 1'b1;
      s = s & (span - 128'sd1);
      if (s >= lim) s = s - span;
      m_acc[k] = s;
      if (m_cnt[k] < (1 << cw[k]) - 1) m_cnt[k]++;
      e.acc[k] = m_acc[k];
      e.cnt[k] = m_cnt[k];
      e.ovf[k] = m_ovf[k];
    end
    if (last) begin
      exp_q.push_back(e);
      model_clear();
    end
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input logic [63:0] p, input bit last);
    int n = 0;
    in_valid = 1'b1;
    product  = p;
    in_last  = last;
    while (!rdy_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("send_timeout", 1, 0);
    else model_accept(p, last);
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  // Monitor: samples shortly after the falling edge, pops on each handshake.
  bit prev_pop = 1'b0;
  int results  = 0;
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      check_eq("ready_vs_valid", rdy_a, !vld_a);
      if (prev_pop) check_eq("ovalid_one_cycle", vld_a, 0);
      prev_pop = vld_a && out_ready;
      if (vld_a && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          results++;
          $display("result %0d: acc=%0d terms=%0d ovf=%0d", results,
                   $signed(acc_a), terms_a, ovf_a);
          check_eq("acc_a", $signed(acc_a), $signed(e.acc[0]));
          check_eq("terms_a", terms_a, e.cnt[0]);
          check_eq("ovf_a", ovf_a, e.ovf[0]);
          check_eq("acc_b", $signed(acc_b), $signed(e.acc[1]));
          check_eq("terms_b", terms_b, e.cnt[1]);
          check_eq("ovf_b", ovf_b, e.ovf[1]);
          check_eq("acc_c", $signed(acc_c), $signed(e.acc[2]));
          check_eq("terms_c", terms_c, e.cnt[2]);
          check_eq("ovf_c", ovf_c, e.ovf[2]);
          check_eq("valid_b", vld_b, 1);
          check_eq("valid_c", vld_c, 1);
        end
      end
    end else begin
      prev_pop = 1'b0;
    end
  end

  task automatic check_cleared(input string tag);
    check_eq({tag, "_acc_a"}, acc_a, 0);
    check_eq({tag, "_terms_a"}, terms_a, 0);
    check_eq({tag, "_ovf_a"}, ovf_a, 0);
    check_eq({tag, "_valid_a"}, vld_a, 0);
    check_eq({tag, "_acc_b"}, acc_b, 0);
    check_eq({tag, "_terms_c"}, terms_c, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 check_cleared("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("reset_in_ready", rdy_a, 1);

    // Basic three-term vector.
    send(64'd6, 0);
    send(-64'sd4, 0);
    send(64'd10, 1);
    idle(3);

    // Backpressure: result held while the next product waits.
    out_ready = 1'b0;
    send(64'h8000_0000_FFFF_FFFF, 1);
    in_valid = 1'b1;
    product  = 64'd99;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_valid", vld_a, 1);
      check_eq("hold_in_ready", rdy_a, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(64'd99, 1);
    idle(3);

    // Overflow in the 66-bit variant, then a clean follow-up vector.
    for (int i = 0; i < 5; i++) send(64'h7FFF_FFFF_FFFF_FFFF, i == 4);
    send(64'd1, 1);
    idle(3);

    // Term counter saturation in the 3-bit variant.
    for (int i = 0; i < 10; i++) send(64'd1, i == 9);
    idle(3);

    // Asynchronous reset in the middle of a vector.
    send(64'd50, 0);
    send(64'd50, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    #3 reset = 1'b1;
    #1 check_cleared("async_reset");
    #1 reset = 1'b0;
    model_clear();
    @(negedge clk);
    send(64'd3, 1);
    idle(3);

    // Multiplier products 2*7 and -3*5 back to back.
    send(64'd14, 0);
    send(-64'sd15, 1);
    idle(4);

    check_eq("pending_results", exp_q.size(), 0);
    check_eq("result_count", results, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
